updown_mod_counter: RTL
=======================

// Module: updown_mod_counter
// PURPOSE
//   Parametrised up/down modulo counter; next generation of the team's fixed 4-bit up-counter.
//   Adds a programmable modulus, direction control, synchronous clear and load, and an enable prescaler.
//   Adds wrap and terminal-count flags, so timers, baud dividers and sequencers can use one counter.
//   Sits directly on the system clock; all control inputs are synchronous to clk.
// PARAMETERS
//   N        4   counter width in bits
//   MODULUS  16  count range 0..MODULUS-1; legal 2 <= MODULUS <= 2**N
//   PRESCALE 1   enabled cycles per count step; legal >= 1 (1 = step every enabled cycle)
// PORTS
//   clk       in   1  rising-edge clock
//   rst       in   1  asynchronous active-high reset
//   enable    in   1  advances prescaler/counter when high; holds state when low
//   up_dn     in   1  1 = count up, 0 = count down; sampled on step cycles
//   clr       in   1  synchronous clear
//   load      in   1  synchronous load of load_val
//   load_val  in   N  value to load
//   out       out  N  current count (registered)
//   at_tc     out  1  combinational: out == MODULUS-1 when up_dn=1, out == 0 when up_dn=0
//   wrap      out  1  registered one-cycle pulse, high in the cycle out shows a wrapped value
//   ovf       out  1  sticky: set on any wrap, cleared only by clr or rst
// BEHAVIOUR
//   - Reset (rst=1, async, any time): out=0, wrap=0, ovf=0, prescaler=0. Takes effect immediately, mid-step included.
//   - Prescaler: internal count p, width max(1,$clog2(PRESCALE)).
//     - enable=1: p increments.
//     - enable=1 with p==PRESCALE-1: a step occurs this edge and p returns to 0.
//     - enable=0: p holds.
//   - Priority at each rising edge: clr > load > step > hold.
//   - clr=1: out=0, p=0, ovf=0, wrap=0; enable, load and up_dn are ignored.
//   - load=1 (clr=0): out=load_val if load_val<MODULUS, else MODULUS-1 (saturate).
//     - Also p=0 and wrap=0; ovf is unchanged; no step occurs this cycle.
//   - Step, up_dn=1: out==MODULUS-1 -> out=0, wrap=1, ovf=1; otherwise out=out+1.
//   - Step, up_dn=0: out==0 -> out=MODULUS-1, wrap=1, ovf=1; otherwise out=out-1.
//   - Any edge without a wrapping step: wrap=0. wrap is never high two cycles running unless wraps occur back-to-back.
//   - Direction change takes effect on the next step; no extra latency; p is not reset.
//   - Latency: out changes on the same edge that samples clr/load/step (1 clock from the input to the registered output).
//   - Arithmetic: out never leaves 0..MODULUS-1 after reset, clr, load or step.
//     - When MODULUS==2**N, the wrap compare still applies (natural binary roll-over).
//   - at_tc follows up_dn combinationally: it is valid during the cycle before the wrapping step.
//   - Illegal parameters (MODULUS<2, MODULUS>2**N, PRESCALE<1): flagged by an elaboration-time check; no runtime behaviour is defined.
// TESTING
//   Default bench parameters: N=4, MODULUS=10, PRESCALE=1; 10 ns clock.
//   1 rst=1 for 4 cycles, then 0; enable=1, up_dn=1 for 12 cycles -> out 0,1..9,0,1.
//     wrap high only in the cycle out=0 after 9; ovf=1 from then on; at_tc=1 when out=9.
//   2 from out=0, up_dn=0, enable=1 -> out 9,8,7; wrap pulses with the first 9; ovf=1.
//     Then clr=1 for one cycle -> out=0, ovf=0, wrap=0.
//   3 load=1, load_val=6 -> out=6 next edge. load_val=13 -> out=9 (saturated).
//     load and clr together -> out=0. load with enable=1 -> no extra step that cycle.
//   4 enable toggled 1/0 each cycle while counting up -> out advances only on enabled edges.
//     Drop enable at out=9 -> out, wrap and ovf all hold.
//   5 rebuild with PRESCALE=3, enable=1 -> out steps every 3rd cycle.
//     load mid-count resets the prescaler, so the next step comes 3 enabled cycles after the load.
//   6 rst asserted asynchronously between edges while out=7 and p=1 -> out=0, flags=0 immediately.
//     Counting resumes from 0 after the first edge following rst release.

Source files
------------

// File: rtl/updown_mod_counter.sv
// ============================================================================
// Module      : updown_mod_counter
// Description : Parametrised up/down modulo counter with an enable prescaler,
//               synchronous clear and saturating load, a combinational
//               terminal-count flag, a one-cycle wrap pulse and a sticky
//               overflow flag.
//
// Parameters  : N        counter width in bits
//               MODULUS  count range 0..MODULUS-1 (2 <= MODULUS <= 2**N)
//               PRESCALE enabled cycles per count step (>= 1)
//
// Ports       : clk       rising-edge clock
//               rst       asynchronous active-high reset
//               enable    advances prescaler/counter when high
//               up_dn     1 = count up, 0 = count down
//               clr       synchronous clear (highest priority)
//               load      synchronous load of load_val (saturated)
//               load_val  value to load
//               out       current count (registered)
//               at_tc     out is at the terminal value for the current direction
//               wrap      one-cycle pulse in the cycle out shows a wrapped value
//               ovf       sticky wrap flag, cleared by clr or rst
//
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module updown_mod_counter #(
    parameter int N        = 4,
    parameter int MODULUS  = 16,
    parameter int PRESCALE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  logic         up_dn,
    input  logic         clr,
    input  logic         load,
    input  logic [N-1:0] load_val,
    output logic [N-1:0] out,
    output logic         at_tc,
    output logic         wrap,
    output logic         ovf
);

    // Prescaler width: at least one bit even when PRESCALE is 1.
    localparam int            c_PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_PW-1:0] c_PMAX = c_PW'(PRESCALE - 1);
    localparam logic [N-1:0]  c_MAX  = N'(MODULUS - 1);
    // One bit wider than the counter so MODULUS == 2**N is representable.
    localparam logic [N:0]    c_MODX = (N + 1)'(MODULUS);

    generate
        if (MODULUS < 2 || MODULUS > (2 ** N) || PRESCALE < 1) begin : g_bad_params
            $error("updown_mod_counter: illegal MODULUS/PRESCALE for width N");
        end
    endgenerate

    logic [N-1:0]    r_out;
    logic [c_PW-1:0] r_p;
    logic            r_wrap;
    logic            r_ovf;

    logic            w_step;
    logic [N-1:0]    w_load_sat;

    // A step happens on the enabled cycle that completes a prescale period.
    assign w_step     = enable && (r_p == c_PMAX);
    assign w_load_sat = ({1'b0, load_val} < c_MODX) ? load_val : c_MAX;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out  <= '0;
            r_p    <= '0;
            r_wrap <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (clr) begin
            r_out  <= '0;
            r_p    <= '0;
            r_wrap <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (load) begin
            // Load restarts the prescale period and suppresses any step.
            r_out  <= w_load_sat;
            r_p    <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (enable) begin
                r_p <= w_step ? '0 : (r_p + c_PW'(1));
            end
            if (w_step) begin
                if (up_dn) begin
                    if (r_out == c_MAX) begin
                        r_out  <= '0;
                        r_wrap <= 1'b1;
                        r_ovf  <= 1'b1;
                    end else begin
                        r_out <= r_out + N'(1);
                    end
                end else begin
                    if (r_out == '0) begin
                        r_out  <= c_MAX;
                        r_wrap <= 1'b1;
                        r_ovf  <= 1'b1;
                    end else begin
                        r_out <= r_out - N'(1);
                    end
                end
            end
        end
    end

    assign out   = r_out;
    assign wrap  = r_wrap;
    assign ovf   = r_ovf;
    // Combinational on up_dn so a direction change is reflected immediately.
    assign at_tc = up_dn ? (r_out == c_MAX) : (r_out == '0);

endmodule

`default_nettype wire
